control_unit: RTL

Multi-cycle sequencer for the Cortex-M0 core that sits directly upstream of the datapath. It steps each instruction through fetch, decode, execute, writeback and PC-advance. It drives the datapath's phase strobes and register load enables, and consumes the datapath's status outputs (`update_flags`, `write_rd`, `ig_ex`, `br_en`). It also provides a halt handshake and a retired-instruction counter for debug.

---
 rtl/control_unit.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Multi-cycle sequencer for the Cortex-M0 core. Each instruction is stepped
// through FETCH -> DECODE -> EXECUTE -> WRITEBACK -> ADVANCE. Condition-failed
// instructions skip straight from DECODE to ADVANCE, and taken branches go
// from EXECUTE to BRANCH. A debug halt is honoured only on FETCH exit, so an
// instruction that has already left FETCH always completes.
//
// Parameters
//   FETCH_WAIT   : extra FETCH cycles for memory read latency (0..15)
//
// Ports
//   clk          : system clock, rising edge
//   rst          : asynchronous, active-high reset
//   update_flags : datapath S bit, instruction updates APSR
//   write_rd     : datapath request to write Rd
//   ig_ex        : datapath condition failed, skip execution
//   br_en        : datapath branch request
//   halt_req     : debug halt request
//   wr_en        : memory write enable (reserved, held 0)
//   branch       : select branch target into PC
//   new_pc_en    : sequential PC advance strobe
//   cu_decode    : decode phase strobe
//   cu_execute   : execute phase strobe
//   ld_sp        : SP load enable (reserved, held 0)
//   ld_lr        : LR load enable
//   ld_pc        : PC load enable
//   ld_rd        : Rd load enable
//   ld_apsr      : APSR load enable
//   ld_ipsr      : IPSR load enable (reserved, held 0)
//   ld_primask   : PRIMASK load enable (reserved, held 0)
//   halted       : core parked in HALT
//   state        : current state encoding, for debug
//   inst_count   : retired-instruction count, wraps at 2^32
// -----------------------------------------------------------------------------
module control_unit #(
    parameter int unsigned FETCH_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        update_flags,
    input  logic        write_rd,
    input  logic        ig_ex,
    input  logic        br_en,
    input  logic        halt_req,
    output logic        wr_en,
    output logic        branch,
    output logic        new_pc_en,
    output logic        cu_decode,
    output logic        cu_execute,
    output logic        ld_sp,
    output logic        ld_lr,
    output logic        ld_pc,
    output logic        ld_rd,
    output logic        ld_apsr,
    output logic        ld_ipsr,
    output logic        ld_primask,
    output logic        halted,
    output logic [2:0]  state,
    output logic [31:0] inst_count
);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_ADVANCE   = 3'd5,
        S_BRANCH    = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(FETCH_WAIT);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  w_next_wait;
    logic [31:0] r_inst_count;
    logic        w_retire;

    // State register, fetch wait counter and retired-instruction counter.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_RESET;
            r_wait_cnt   <= 4'd0;
            r_inst_count <= 32'd0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait;
            if (w_retire) begin
                r_inst_count <= r_inst_count + 32'd1;
            end
        end
    end

    // Next-state and output decode. Strobes are Moore outputs of the
    // registered state, except ld_rd/ld_apsr which pass the datapath status
    // straight through while in WRITEBACK.
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        w_next_state = r_state;
        w_next_wait  = r_wait_cnt;
        w_retire     = 1'b0;
        wr_en        = 1'b0;
        branch       = 1'b0;
        new_pc_en    = 1'b0;
        cu_decode    = 1'b0;
        cu_execute   = 1'b0;
        ld_sp        = 1'b0;
        ld_lr        = 1'b0;
        ld_pc        = 1'b0;
        ld_rd        = 1'b0;
        ld_apsr      = 1'b0;
        ld_ipsr      = 1'b0;
        ld_primask   = 1'b0;
        halted       = 1'b0;

        case (r_state)
            S_RESET: begin
                w_next_state = S_FETCH;
                w_next_wait  = WAIT_INIT;
            end
            S_FETCH: begin
                if (r_wait_cnt != 4'd0) begin
                    w_next_wait = r_wait_cnt - 4'd1;
                end else if (halt_req) begin
                    // Halt only between instructions: PC has not moved, so
                    // the same instruction is fetched again after HALT.
                    w_next_state = S_HALT;
                end else begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                cu_decode    = 1'b1;
                w_next_state = ig_ex ? S_ADVANCE : S_EXECUTE;
            end
            S_EXECUTE: begin
                cu_execute   = 1'b1;
                w_next_state = br_en ? S_BRANCH : S_WRITEBACK;
            end
            S_WRITEBACK: begin
                ld_rd        = write_rd;
                ld_apsr      = update_flags;
                w_next_state = S_ADVANCE;
            end
            S_ADVANCE: begin
                new_pc_en    = 1'b1;
                ld_pc        = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
                w_next_wait  = WAIT_INIT;
            end
            S_BRANCH: begin
                branch       = 1'b1;
                ld_pc        = 1'b1;
                ld_lr        = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
                w_next_wait  = WAIT_INIT;
            end
            S_HALT: begin
                halted = 1'b1;
                if (!halt_req) begin
                    w_next_state = S_FETCH;
                    w_next_wait  = WAIT_INIT;
                end
            end
            default: begin
                w_next_state = S_RESET;
            end
        endcase
    end

    assign state      = r_state;
    assign inst_count = r_inst_count;

endmodule
